// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard for an in-order issue stage.
// Two combinational read ports report data and pending-write status, one
// writeback port stores results and retires pending writes, and one reservation
// port marks a destination as pending. A flush drops every pending reservation.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the
// read ports.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            rsv_en,
    input  logic [4:0]      rsv_addr,
    output logic            rsv_ready,
    input  logic            rd_en,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            flush,
    output logic [5:0]      busy_cnt
);

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREGS-1:0]           busy_q, busy_d;
    logic                       wb_ok;
    logic                       rsv_ok;

    // Indices 0 and >= NREGS are not real storage; they never write or reserve.
    assign wb_ok  = rd_en && (rd_addr != 5'd0) && ({1'b0, rd_addr} < NREGS_L);
    assign rsv_ok = (rsv_addr != 5'd0) && ({1'b0, rsv_addr} < NREGS_L);

    // Read ports: a decoded mux, so out-of-range indices match nothing and read 0.
    // Entry 0 is reset to 0 and never written, so x0 reads as 0 through the mux.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (rs1_addr == 5'(i)) begin
                rs1_data = regs_q[i];
                rs1_busy = busy_q[i];
            end
            if (rs2_addr == 5'(i)) begin
                rs2_data = regs_q[i];
                rs2_busy = busy_q[i];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (wb_ok && (rd_addr == rs1_addr)) begin
            rs1_data = rd_data;
            rs1_busy = 1'b0;
        end
        if (wb_ok && (rd_addr == rs2_addr)) begin
            rs2_data = rd_data;
            rs2_busy = 1'b0;
        end
`endif
    end

    // WAW stall: refuse a busy destination unless this cycle's writeback retires it.
    always_comb begin
        rsv_ready = 1'b1;
        for (int i = 1; i < NREGS; i++) begin
            if ((rsv_addr == 5'(i)) && busy_q[i] && !(rd_en && (rd_addr == rsv_addr)))
                rsv_ready = 1'b0;
        end
    end

    // Population count of pending destinations.
    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREGS; i++)
            busy_cnt = busy_cnt + 6'(busy_q[i]);
    end

    // Next state: writeback clears busy first, then flush or reservation applies,
    // so a reservation on the writeback target ends with busy set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (wb_ok && (rd_addr == 5'(i))) begin
                regs_d[i] = rd_data;
                busy_d[i] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (rsv_en && rsv_ready && rsv_ok) begin
            for (int i = 1; i < NREGS; i++) begin
                if (rsv_addr == 5'(i))
                    busy_d[i] = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a vector table on the default 32-entry
// instance plus hand sequences for reset sweep and a 16-entry (RV32E) instance.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-register instance
    logic        rst, rsv_en, rd_en, flush;
    logic [4:0]  rs1_addr, rs2_addr, rsv_addr, rd_addr;
    logic [31:0] rd_data, rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy, rsv_ready;
    logic [5:0]  busy_cnt;

    // 16-register instance
    logic        s_rst, s_rsv_en, s_rd_en, s_flush;
    logic [4:0]  s_rs1_addr, s_rs2_addr, s_rsv_addr, s_rd_addr;
    logic [31:0] s_rd_data, s_rs1_data, s_rs2_data;
    logic        s_rs1_busy, s_rs2_busy, s_rsv_ready;
    logic [5:0]  s_busy_cnt;

    regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(16)) dut16 (
        .clk(clk), .rst(s_rst), .rs1_addr(s_rs1_addr), .rs2_addr(s_rs2_addr),
        .rs1_data(s_rs1_data), .rs2_data(s_rs2_data), .rs1_busy(s_rs1_busy), .rs2_busy(s_rs2_busy),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr), .rsv_ready(s_rsv_ready),
        .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .flush(s_flush), .busy_cnt(s_busy_cnt)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2;
        logic        rsv_en;
        logic [4:0]  rsv;
        logic        rd_en;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        fl;
        logic [31:0] e1, e2;
        logic        b1, b2, rdy;
        logic [5:0]  cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; rs1_addr = v.rs1; rs2_addr = v.rs2;
        rsv_en = v.rsv_en; rsv_addr = v.rsv;
        rd_en = v.rd_en; rd_addr = v.rd; rd_data = v.wd; flush = v.fl;
    endtask

    task automatic s_idle();
        s_rst = 1'b1; s_rs1_addr = 5'd0; s_rs2_addr = 5'd0; s_rsv_en = 1'b0; s_rsv_addr = 5'd0;
        s_rd_en = 1'b0; s_rd_addr = 5'd0; s_rd_data = 32'd0; s_flush = 1'b0;
    endtask

    initial begin
        // {rst, rs1, rs2, rsv_en, rsv, rd_en, rd, wd, flush | rs1_data, rs2_data, rs1_busy, rs2_busy, rsv_ready, busy_cnt}
        // Expected outputs are sampled before the edge that consumes the inputs.
        tbl[0]  = '{1, 5, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[2]  = '{1, 5, 0, 0, 5, 1, 5, 32'hDEADBEEF, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, BYP ? 1'b0 : 1'b1, 0, 1, 1};
        tbl[3]  = '{1, 5, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 0, 1, 0};
        tbl[4]  = '{1, 7, 5, 1, 7, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 1, 0};
        tbl[5]  = '{1, 7, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
        tbl[6]  = '{1, 7, 0, 1, 7, 1, 7, 32'h77, 0, BYP ? 32'h77 : 32'h0, 0, BYP ? 1'b0 : 1'b1, 0, 1, 1};
        tbl[7]  = '{1, 7, 0, 0, 7, 0, 0, 0, 0, 32'h77, 0, 1, 0, 0, 1};
        tbl[8]  = '{1, 1, 7, 1, 1, 0, 0, 0, 0, 0, 32'h77, 0, 1, 1, 1};
        tbl[9]  = '{1, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2};
        tbl[10] = '{1, 2, 3, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3};
        tbl[11] = '{1, 2, 3, 1, 4, 1, 2, 32'h1234, 1, BYP ? 32'h1234 : 32'h0, 0, BYP ? 1'b0 : 1'b1, 1, 1, 4};
        tbl[12] = '{1, 2, 4, 0, 4, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 1, 0};
        tbl[13] = '{1, 0, 9, 0, 9, 1, 9, 32'hA5A5A5A5, 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0, 0, 0, 1, 0};
        tbl[14] = '{1, 9, 9, 0, 9, 0, 0, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 0};
        tbl[15] = '{1, 0, 0, 1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0};
        tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[17] = '{1, 10, 0, 1, 10, 1, 10, 32'hABC, 0, BYP ? 32'hABC : 32'h0, 0, 0, 0, 1, 0};
        tbl[18] = '{1, 10, 0, 0, 10, 0, 0, 0, 0, 32'hABC, 0, 1, 0, 0, 1};
        tbl[19] = '{1, 31, 0, 1, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        tbl[20] = '{1, 31, 10, 0, 31, 0, 0, 0, 0, 0, 32'hABC, 1, 1, 0, 2};
        tbl[21] = '{0, 9, 10, 1, 11, 1, 9, 32'h1, 0, BYP ? 32'h1 : 32'hA5A5A5A5, 32'hABC, 0, 1, 1, 2};
        tbl[22] = '{1, 9, 10, 0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        // Reset both instances
        drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        s_idle();
        s_rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        s_rst = 1'b1;

        // Post-reset sweep of every index on both read ports
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); rsv_addr = 5'(i);
            #1;
            chk("rst_rs1_data", i, rs1_data, 32'h0);
            chk("rst_rs2_data", i, rs2_data, 32'h0);
            chk("rst_busy", i, {30'd0, rs1_busy, rs2_busy}, 32'h0);
            chk("rst_rsv_ready", i, {31'd0, rsv_ready}, 32'h1);
            chk("rst_busy_cnt", i, {26'd0, busy_cnt}, 32'h0);
        end

        // Table: apply each vector, check combinational outputs before the edge
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            drive(tbl[v]);
            #1;
            chk("rs1_data", v, rs1_data, tbl[v].e1);
            chk("rs2_data", v, rs2_data, tbl[v].e2);
            chk("rs1_busy", v, {31'd0, rs1_busy}, {31'd0, tbl[v].b1});
            chk("rs2_busy", v, {31'd0, rs2_busy}, {31'd0, tbl[v].b2});
            chk("rsv_ready", v, {31'd0, rsv_ready}, {31'd0, tbl[v].rdy});
            chk("busy_cnt", v, {26'd0, busy_cnt}, {26'd0, tbl[v].cnt});
        end

        // RV32E instance: indices >= 16 must not alias onto low registers
        @(negedge clk);
        s_rd_en = 1'b1; s_rd_addr = 5'd20; s_rd_data = 32'h1;
        s_rsv_en = 1'b1; s_rsv_addr = 5'd20; s_rs1_addr = 5'd20; s_rs2_addr = 5'd4;
        #1;
        chk("e_pre_rdy20", 0, {31'd0, s_rsv_ready}, 32'h1);
        chk("e_pre_rs1_20", 0, s_rs1_data, 32'h0);
        chk("e_pre_busy20", 0, {31'd0, s_rs1_busy}, 32'h0);
        @(negedge clk);
        s_rd_en = 1'b0; s_rsv_en = 1'b0;
        #1;
        chk("e_rs1_20", 0, s_rs1_data, 32'h0);
        chk("e_busy20", 0, {31'd0, s_rs1_busy}, 32'h0);
        chk("e_rs2_x4", 0, s_rs2_data, 32'h0);
        chk("e_busy4", 0, {31'd0, s_rs2_busy}, 32'h0);
        chk("e_cnt0", 0, {26'd0, s_busy_cnt}, 32'h0);

        // Top valid index writes; index 16 reservation is ignored
        @(negedge clk);
        s_rd_en = 1'b1; s_rd_addr = 5'd15; s_rd_data = 32'hF;
        s_rsv_en = 1'b1; s_rsv_addr = 5'd16;
        #1;
        chk("e_rdy16", 0, {31'd0, s_rsv_ready}, 32'h1);
        @(negedge clk);
        s_rd_en = 1'b0; s_rsv_en = 1'b0; s_rs1_addr = 5'd15; s_rs2_addr = 5'd16;
        #1;
        chk("e_rs1_15", 0, s_rs1_data, 32'hF);
        chk("e_rs2_16", 0, s_rs2_data, 32'h0);
        chk("e_cnt_16", 0, {26'd0, s_busy_cnt}, 32'h0);

        // Reserve x15 and see it busy
        @(negedge clk);
        s_rsv_en = 1'b1; s_rsv_addr = 5'd15;
        @(negedge clk);
        s_rsv_en = 1'b0;
        #1;
        chk("e_busy15", 0, {31'd0, s_rs1_busy}, 32'h1);
        chk("e_cnt15", 0, {26'd0, s_busy_cnt}, 32'h1);
        chk("e_rdy15", 0, {31'd0, s_rsv_ready}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers; legal values are 16 (RV32E) and 32.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port rs1_addr  input  5  meaning read port 1 register index.
REQ-006 The block SHALL have port rs2_addr  input  5  meaning read port 2 register index.
REQ-007 The block SHALL have port rs1_data  output  XLEN  meaning read port 1 data.
REQ-008 The block SHALL have port rs2_data  output  XLEN  meaning read port 2 data.
REQ-009 The block SHALL have port rs1_busy  output  1  meaning the rs1_addr register has a pending write.
REQ-010 The block SHALL have port rs2_busy  output  1  meaning the rs2_addr register has a pending write.
REQ-011 The block SHALL have port rsv_en  input  1  meaning an issue request to reserve rsv_addr as a pending destination.
REQ-012 The block SHALL have port rsv_addr  input  5  meaning the destination index to reserve.
REQ-013 The block SHALL have port rsv_ready  output  1  meaning a reservation of rsv_addr is accepted this cycle.
REQ-014 The block SHALL have port rd_en  input  1  meaning writeback valid.
REQ-015 The block SHALL have port rd_addr  input  5  meaning writeback index.
REQ-016 The block SHALL have port rd_data  input  XLEN  meaning writeback data.
REQ-017 The block SHALL have port flush  input  1  meaning clear all pending reservations (pipeline flush).
REQ-018 The block SHALL have port busy_cnt  output  6  meaning the number of registers currently marked busy.

Function
REQ-019 Reads SHALL be combinational (zero latency); an index of 0 or an index >= NREGS SHALL read 0 with busy 0.
REQ-020 On a clock edge with rd_en=1, rd_addr!=0 and rd_addr<NREGS, the block SHALL store rd_data and clear busy[rd_addr]; all other writebacks are ignored.
REQ-021 rsv_ready SHALL be 1 when rsv_addr is 0, or is >= NREGS, or busy[rsv_addr]=0, or (rd_en=1 and rd_addr=rsv_addr); otherwise 0 (WAW stall).
REQ-022 On a clock edge with rsv_en=1, rsv_ready=1, flush=0, rsv_addr!=0 and rsv_addr<NREGS, the block SHALL set busy[rsv_addr]; x0 SHALL never become busy.
REQ-023 When a writeback and a reservation target the same index on the same edge, the data SHALL be written and busy SHALL end set (the reservation wins).
REQ-024 On an edge with flush=1, all busy bits SHALL clear and any reservation is dropped; a writeback on the same edge SHALL still update data.
REQ-025 busy_cnt SHALL equal the population count of the busy bits, combinationally; its range is 0..NREGS-1.
REQ-026 A writeback to a register that is not busy SHALL update the data and leave busy at 0.

Reset
REQ-027 While rst=0 at a clock edge, all data registers SHALL become 0 and all busy bits SHALL become 0, overriding rd_en, rsv_en and flush.
REQ-028 After reset, all read data SHALL be 0, rs1_busy=rs2_busy=0, busy_cnt=0, and rsv_ready=1.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
- When REGFILE_BYPASS_EN is defined: if rd_en=1 with a valid nonzero rd_addr equal to rsN_addr, rsN_data SHALL return rd_data and rsN_busy SHALL read 0 in that same cycle.
- When REGFILE_BYPASS_EN is not defined: reads SHALL return the stored value and the stored busy bit; a written value is visible from the cycle after the edge.

Verification
REQ-030 Apply reset, then read indices 0..31 -> all data 0, busy 0, busy_cnt=0.
REQ-031 Reserve x5, then on the next cycle read rs1_addr=5 -> rs1_busy=1 and busy_cnt=1; write back x5=32'hDEADBEEF -> next cycle rs1_data=32'hDEADBEEF, rs1_busy=0, busy_cnt=0.
REQ-032 With x7 busy, drive rsv_en with rsv_addr=7 and rd_en=0 -> rsv_ready=0; add rd_en with rd_addr=7 -> rsv_ready=1, and after the edge x7 holds the new data and is still busy.
REQ-033 Reserve x1, x2 and x3, then assert flush together with a writeback x2=32'h1234 -> busy_cnt=0 and x2 reads 32'h1234.
REQ-034 Write x9=32'hA5A5A5A5 while rs2_addr=9 -> rs2_data=32'hA5A5A5A5 in the same cycle only when REGFILE_BYPASS_EN is defined, otherwise the old value.
REQ-035 With NREGS=16, write x20=1 and reserve x20 -> no state change, rs1_addr=20 reads 0 with busy 0, and x0 writes and reservations are likewise ignored.
